// File: rtl/conv3x3_engine_if.sv
// Handshake and data bundle between the 3x3 convolution engine and its neighbours:
// weight loader, window fetch and result write-back.
interface conv3x3_engine_if;
  logic        i_w_done;
  logic [71:0] i_weights;
  logic        i_win_valid;
  logic [71:0] i_win_data;
  logic        o_win_ready;
  logic        o_out_valid;
  logic [7:0]  o_out_data;
  logic        o_last;
  logic        i_out_ready;
  logic        o_busy;

  modport master (
    output i_w_done, i_weights, i_win_valid, i_win_data, i_out_ready,
    input  o_win_ready, o_out_valid, o_out_data, o_last, o_busy
  );

  modport slave (
    input  i_w_done, i_weights, i_win_valid, i_win_data, i_out_ready,
    output o_win_ready, o_out_valid, o_out_data, o_last, o_busy
  );
endinterface

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: registered products, row sums, then round/shift/clamp to an 8-bit pixel.
// Weights are latched once per frame and a frame is NUM_OUT results long.
module conv3x3_engine #(
  parameter int SHIFT   = 7,
  parameter int NUM_OUT = 4096
) (
  input logic             i_clk,
  input logic             i_rst,
  conv3x3_engine_if.slave bus
);
  localparam int CW = $clog2(NUM_OUT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OUT - 1);
  localparam logic [CW-1:0] IN_LIMIT = CW'(NUM_OUT);
  localparam logic signed [21:0] RND = 22'sd1 <<< (SHIFT - 1);

  typedef enum logic {S_WAIT_W, S_RUN} state_e;

  state_e             state_q;
  logic [71:0]        weights_q;
  logic [CW-1:0]      outCnt_q;
  logic [CW-1:0]      inCnt_q;
  logic signed [16:0] prod_d [9];
  logic signed [16:0] prod_q [9];
  logic signed [18:0] rowSum_d [3];
  logic signed [18:0] rowSum_q [3];
  logic               s1Valid_q;
  logic               s2Valid_q;
  logic               outValid_q;
  logic [7:0]         outData_q;
  logic [7:0]         pix_d;
  logic signed [20:0] total;
  logic signed [21:0] shifted;
  logic               stall;
  logic               winReady;
  logic               accept;
  logic               consume;

  assign stall    = outValid_q & ~bus.i_out_ready;
  assign winReady = (state_q == S_RUN) & ~stall & (inCnt_q < IN_LIMIT);
  assign accept   = bus.i_win_valid & winReady;
  assign consume  = outValid_q & bus.i_out_ready;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = $signed({9'b0, bus.i_win_data[71-8*k -: 8]})
                * $signed({{9{weights_q[71-8*k]}}, weights_q[71-8*k -: 8]});
    end
    for (int r = 0; r < 3; r++) begin
      rowSum_d[r] = 19'(prod_q[3*r]) + 19'(prod_q[3*r+1]) + 19'(prod_q[3*r+2]);
    end
    total   = 21'(rowSum_q[0]) + 21'(rowSum_q[1]) + 21'(rowSum_q[2]);
    shifted = (22'(total) + RND) >>> SHIFT;
    pix_d   = shifted[7:0];
    if (shifted[21]) begin
      pix_d = 8'd0;
    end else if (shifted > 22'sd255) begin
      pix_d = 8'd255;
    end
  end

  // Frame control: weights are frozen from i_w_done until the last result leaves.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_WAIT_W;
      weights_q <= '0;
      outCnt_q  <= '0;
      inCnt_q   <= '0;
    end else begin
      if (accept) begin
        inCnt_q <= inCnt_q + CW'(1);
      end
      case (state_q)
        S_WAIT_W: begin
          if (bus.i_w_done) begin
            weights_q <= bus.i_weights;
            outCnt_q  <= '0;
            inCnt_q   <= '0;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (consume) begin
            if (outCnt_q == LAST_IDX) begin
              outCnt_q <= '0;
              state_q  <= S_WAIT_W;
            end else begin
              outCnt_q <= outCnt_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  // The whole pipeline freezes while a result waits on the downstream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1Valid_q  <= 1'b0;
      s2Valid_q  <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      for (int r = 0; r < 3; r++) rowSum_q[r] <= '0;
    end else if (!stall) begin
      s1Valid_q  <= accept;
      s2Valid_q  <= s1Valid_q;
      outValid_q <= s2Valid_q;
      if (accept)    prod_q    <= prod_d;
      if (s1Valid_q) rowSum_q  <= rowSum_d;
      if (s2Valid_q) outData_q <= pix_d;
    end
  end

  assign bus.o_win_ready = winReady;
  assign bus.o_out_valid = outValid_q;
  assign bus.o_out_data  = outData_q;
  assign bus.o_last      = outValid_q & (outCnt_q == LAST_IDX);
  assign bus.o_busy      = (state_q == S_RUN) | s1Valid_q | s2Valid_q | outValid_q;
endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: dutA (16-result frames) covers the datapath and
// backpressure, dutB (4-result frames) shares the same stimulus and covers frame ends.
module tb_conv3x3_engine;
  localparam logic [71:0] IDENT    = 72'h00000000_40_00000000;
  localparam logic [71:0] QUARTER  = 72'h00000000_20_00000000;
  localparam logic [71:0] ALL_POS  = 72'h7F7F7F7F7F7F7F7F7F;
  localparam logic [71:0] ALL_NEG  = 72'h808080808080808080;
  localparam logic [71:0] ALL_FF   = 72'hFFFFFFFFFFFFFFFFFF;
  localparam logic [71:0] W0_ONE   = 72'h01_0000000000000000;
  localparam logic [71:0] P0_64    = 72'h40_0000000000000000;
  localparam logic [71:0] P0_63    = 72'h3F_0000000000000000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wDone = 1'b0;
  logic [71:0] weights = '0;
  logic        winValid = 1'b0;
  logic [71:0] winData = '0;
  logic        outReady = 1'b1;

  int testCount = 0;
  int failCount = 0;
  int sent;
  int got;
  int cyc;
  logic stalled;

  conv3x3_engine_if busA ();
  conv3x3_engine_if busB ();

  assign busA.i_w_done    = wDone;
  assign busA.i_weights   = weights;
  assign busA.i_win_valid = winValid;
  assign busA.i_win_data  = winData;
  assign busA.i_out_ready = outReady;
  assign busB.i_w_done    = wDone;
  assign busB.i_weights   = weights;
  assign busB.i_win_valid = winValid;
  assign busB.i_win_data  = winData;
  assign busB.i_out_ready = outReady;

  conv3x3_engine #(.SHIFT(7), .NUM_OUT(16)) dutA (
    .i_clk (clock),
    .i_rst (reset),
    .bus   (busA.slave)
  );

  conv3x3_engine #(.SHIFT(7), .NUM_OUT(4)) dutB (
    .i_clk (clock),
    .i_rst (reset),
    .bus   (busB.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    reset    = 1'b1;
    wDone    = 1'b0;
    winValid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic loadWeights(input logic [71:0] w);
    wDone   = 1'b1;
    weights = w;
    tick();
    wDone = 1'b0;
  endtask

  task automatic applyStimulus(input logic [71:0] data);
    winValid = 1'b1;
    winData  = data;
    tick();
    winValid = 1'b0;
  endtask

  function automatic logic [71:0] identWin(input int i);
    logic [7:0] p;
    p = 8'(20 * i + 10);
    return {32'h0, p, 32'h0};
  endfunction

  // One window through a fresh frame; the result must appear on the third edge.
  task automatic runWindow(input string tag, input logic [71:0] w,
                           input logic [71:0] p, input logic [7:0] expected);
    resetDut();
    loadWeights(w);
    outReady = 1'b1;
    checkOutput({tag, "Ready"}, busA.o_win_ready, 1);
    applyStimulus(p);
    tick();
    checkOutput({tag, "Early"}, busA.o_out_valid, 0);
    tick();
    checkOutput({tag, "Valid"}, busA.o_out_valid, 1);
    checkOutput({tag, "Data"}, busA.o_out_data, expected);
  endtask

  initial begin
    outReady = 1'b1;
    resetDut();
    checkOutput("rstWinReady", busA.o_win_ready, 0);
    checkOutput("rstOutValid", busA.o_out_valid, 0);
    checkOutput("rstOutData", busA.o_out_data, 0);
    checkOutput("rstLast", busA.o_last, 0);
    checkOutput("rstBusy", busA.o_busy, 0);

    runWindow("ident", IDENT, 72'h00000000_C8_00000000, 8'd100);
    runWindow("clampHi", ALL_POS, ALL_FF, 8'd255);
    runWindow("clampLo", ALL_NEG, ALL_FF, 8'd0);
    runWindow("roundUp", W0_ONE, P0_64, 8'd1);
    runWindow("roundDn", W0_ONE, P0_63, 8'd0);

    // Ten windows with i_out_ready cycling 1,0,0.
    resetDut();
    loadWeights(IDENT);
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 10 && cyc < 200) begin
      outReady = (cyc % 3 == 0);
      winValid = (sent < 10);
      winData  = identWin(sent);
      #1;
      stalled = busA.o_out_valid & ~outReady;
      if (sent < 10) checkOutput("bpWinReady", busA.o_win_ready, !stalled);
      if (busA.o_out_valid) begin
        checkOutput("bpData", busA.o_out_data, 5 + 10 * got);
        checkOutput("bpLast", busA.o_last, 0);
        if (outReady) got++;
      end
      if (winValid && busA.o_win_ready) sent++;
      @(posedge clock);
      #1;
      cyc++;
    end
    winValid = 1'b0;
    outReady = 1'b1;
    checkOutput("bpCount", got, 10);

    // Four-result frame on dutB with a fifth window offered throughout.
    resetDut();
    loadWeights(IDENT);
    outReady = 1'b1;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 12; c++) begin
      winValid = 1'b1;
      winData  = identWin(sent);
      #1;
      if (busB.o_out_valid) begin
        checkOutput("frmData", busB.o_out_data, 5 + 10 * got);
        checkOutput("frmLast", busB.o_last, got == 3);
        got++;
      end
      if (busB.o_win_ready) sent++;
      @(posedge clock);
      #1;
    end
    checkOutput("frmAccepted", sent, 4);
    checkOutput("frmResults", got, 4);
    checkOutput("frmBusy", busB.o_busy, 0);
    checkOutput("frmWinReady", busB.o_win_ready, 0);
    winValid = 1'b0;
    loadWeights(QUARTER);
    checkOutput("frm2Ready", busB.o_win_ready, 1);
    applyStimulus(72'h00000000_C8_00000000);
    tick();
    tick();
    checkOutput("frm2Valid", busB.o_out_valid, 1);
    checkOutput("frm2Data", busB.o_out_data, 50);
    checkOutput("frm2Last", busB.o_last, 0);

    // Reset with results in flight, then windows offered while no weights are loaded.
    resetDut();
    loadWeights(IDENT);
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(identWin(i));
    checkOutput("midPreValid", busA.o_out_valid, 1);
    checkOutput("midPreData", busA.o_out_data, 5);
    reset    = 1'b1;
    winValid = 1'b1;
    winData  = identWin(5);
    tick();
    checkOutput("midWinReady", busA.o_win_ready, 0);
    checkOutput("midOutValid", busA.o_out_valid, 0);
    checkOutput("midOutData", busA.o_out_data, 0);
    checkOutput("midLast", busA.o_last, 0);
    checkOutput("midBusy", busA.o_busy, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("midStale", busA.o_out_valid, 0);
      checkOutput("midWaitReady", busA.o_win_ready, 0);
    end
    winValid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
